mem_bus_arbiter: RTL

- Shares one external line-wide memory port between the hart's instruction-fetch port (read-only) and data port (read/write).
- Sits between the hart and the memory model/controller.
- Data writes are posted through a small in-order write buffer.
- Round-robin arbitration between the I side and the D side; D reads are ordered behind all buffered writes.

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between instruction fetch
// and data access; data writes are posted through an in-order FIFO write buffer.
module mem_bus_arbiter #(
    parameter int unsigned AW         = 64,
    parameter int unsigned LW         = 1024,
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_addr,
    input  logic          i_rd,
    output logic [LW-1:0] i_data,
    output logic          i_dv,
    input  logic [AW-1:0] d_addr,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [LW-1:0] d_wdata,
    output logic [LW-1:0] d_rdata,
    output logic          d_dv,
    output logic          d_wbuf_full,
    output logic [AW-1:0] m_addr,
    output logic          m_rd,
    output logic          m_wr,
    output logic [LW-1:0] m_wdata,
    input  logic [LW-1:0] m_rdata,
    input  logic          m_dv
);

    localparam int unsigned PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, I_RD, D_RD, WR} state_t;

    state_t        state, state_nx;
    logic          last_d, last_d_nx;
    logic          i_req, d_req;

    logic [AW-1:0] wb_addr [WBUF_DEPTH];
    logic [LW-1:0] wb_data [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic          push, pop;

    logic [AW-1:0] m_addr_nx;
    logic          m_rd_nx, m_wr_nx;
    logic [LW-1:0] m_wdata_nx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(WBUF_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign i_data  = m_rdata;
    assign d_rdata = m_rdata;
    assign i_dv    = m_dv && (state == I_RD);
    assign d_dv    = m_dv && (state == D_RD);

    // A full buffer drops the incoming pulse rather than overwriting the head.
    assign push = d_wr && (count != CW'(WBUF_DEPTH));

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + CW'(1);
        else if (!push && pop)
            count_nx = count - CW'(1);
    end

    always_comb begin
        state_nx   = state;
        last_d_nx  = last_d;
        m_addr_nx  = m_addr;
        m_rd_nx    = m_rd;
        m_wr_nx    = 1'b0;
        m_wdata_nx = m_wdata;
        pop        = 1'b0;
        i_req      = i_rd;
        d_req      = (count != '0) || d_rd;
        unique case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    state_nx  = I_RD;
                    last_d_nx = 1'b0;
                    m_rd_nx   = 1'b1;
                    m_addr_nx = i_addr;
                end else if (d_req) begin
                    last_d_nx = 1'b1;
                    // Buffered writes always drain ahead of a data read (RAW order).
                    if (count != '0) begin
                        state_nx   = WR;
                        m_wr_nx    = 1'b1;
                        m_addr_nx  = wb_addr[rd_ptr];
                        m_wdata_nx = wb_data[rd_ptr];
                    end else begin
                        state_nx  = D_RD;
                        m_rd_nx   = 1'b1;
                        m_addr_nx = d_addr;
                    end
                end
            end
            I_RD, D_RD: begin
                if (m_dv) begin
                    state_nx = IDLE;
                    m_rd_nx  = 1'b0;
                end
            end
            WR: begin
                pop      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            m_addr      <= '0;
            m_rd        <= 1'b0;
            m_wr        <= 1'b0;
            m_wdata     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            d_wbuf_full <= 1'b0;
        end else begin
            state       <= state_nx;
            last_d      <= last_d_nx;
            m_addr      <= m_addr_nx;
            m_rd        <= m_rd_nx;
            m_wr        <= m_wr_nx;
            m_wdata     <= m_wdata_nx;
            count       <= count_nx;
            d_wbuf_full <= (count_nx == CW'(WBUF_DEPTH));
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= d_addr;
            wb_data[wr_ptr] <= d_wdata;
        end
    end

endmodule
